in_bsg_ctrl: RTL and testbench
==============================

Name: in_bsg_ctrl

Overview:
Sequencer for the input bitstream generator of the folded FC layer. It accepts one input activation vector over a valid/ready handshake and latches it. For each of FOLD output folds, it clears the Sobol RNG and runs the generator for BSL = 2^INWD cycles. It drives the generator's enable, supplies the held input vector, and gives downstream accumulators cycle, pass and done markers.

Parameters:
DIM_IN, 16, number of input activations (lanes) per vector
INWD, 8, activation/RNG width in bits; stream length BSL = 2^INWD
FOLD, 2, passes per vector (one per output fold); legal range 1..16
FW, $clog2(FOLD) with a minimum of 1, width of fold_idx

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream vector valid
in_ready  out  1  controller can accept a vector
in_data  in  DIM_IN*INWD  input activation vector; lane i is in_data[i*INWD +: INWD]
stall  in  1  downstream back-pressure; freezes streaming
abort  in  1  synchronous abort; returns to IDLE
bsg_in  out  DIM_IN*INWD  held vector driven to the generator
bsg_enable  out  1  advances the generator's RNG
rng_clr  out  1  one-cycle synchronous clear of the RNG to sequence start
fold_idx  out  FW  current pass index
cyc_cnt  out  INWD  index of the bitstream bit currently at the comparators
last_cycle  out  1  high while bsg_enable=1 and cyc_cnt=BSL-1
pass_done  out  1  one-cycle pulse after the final bit of each pass
all_done  out  1  one-cycle pulse after the final pass

Behaviour:
- Reset (async, any state): state=IDLE. bsg_in=0, cyc_cnt=0, fold_idx=0. in_ready=1. All other outputs 0. Reset mid-stream discards the vector with no done pulses.
- States: IDLE, CLR, RUN, DONE. Outputs are decoded from registered state and counters; no combinational path from in_valid to in_ready.
- IDLE:
  - in_ready=1.
  - On in_valid=1: in_data is captured into bsg_in; fold_idx=0, cyc_cnt=0; next state CLR.
  - in_ready=0 in every other state. in_valid outside IDLE is ignored; upstream holds it.
- CLR: exactly 1 cycle. rng_clr=1, bsg_enable=0, then RUN. Stall does not extend CLR.
- RUN:
  - bsg_enable = !stall. cyc_cnt increments only when bsg_enable=1.
  - While stall=1, cyc_cnt, fold_idx and bsg_in hold and bsg_enable=0.
  - When bsg_enable=1 and cyc_cnt=BSL-1: last_cycle=1. The next cycle gives a pass_done pulse and cyc_cnt wraps to 0.
    - If fold_idx<FOLD-1: fold_idx+1, next state CLR. pass_done is asserted during that CLR cycle.
    - Else next state DONE. pass_done and all_done are both asserted in the DONE cycle.
  - Each pass has exactly BSL enabled cycles, regardless of how many stall cycles occur.
- DONE: 1 cycle, then IDLE. bsg_in keeps its value until the next capture.
- abort=1 in CLR/RUN/DONE: the next state is IDLE with cyc_cnt=0, fold_idx=0, and no pass_done/all_done. abort in IDLE is ignored. abort has priority over stall and over last-cycle completion.
- FOLD=1: fold_idx stays 0; the only path is CLR→RUN→DONE.
- Unstalled latency (handshake at cycle T):
  - Pass k (k=0..FOLD-1): CLR at T+1+k(BSL+1); RUN over the following BSL cycles.
  - all_done at T+1+FOLD(BSL+1); in_ready high in the next cycle.
- Output invariants:
  - bsg_enable and rng_clr are never high together.
  - last_cycle is never high while bsg_enable=0.

Test Plan:
- Nominal (INWD=8, FOLD=2): vector with lane0=0x40 accepted at T=0 → rng_clr at 1 and 258. bsg_enable high 2..257 and 259..514. pass_done at 258 and 515; all_done at 515; in_ready high at 516. Bench counts lane0 ones = 64 per pass.
- Stall: stall=1 for cycles 100..109 in pass 0 → cyc_cnt frozen at 98, bsg_enable low for 10 cycles. Pass 0 still has 256 enabled cycles; all schedule points shift by +10.
- Stall on last bit: stall=1 while cyc_cnt=255 for 3 cycles → last_cycle low while stalled. It asserts once when stall drops; exactly one pass_done follows.
- Back-to-back: in_valid held continuously with vectors A,B → B not accepted until the cycle after A's all_done. bsg_in changes to B only at B's handshake.
- Abort: abort at cycle 150 of pass 1 → IDLE next cycle, in_ready=1, no all_done. A new vector then runs the full nominal sequence with fold_idx starting at 0.
- Async reset: rst pulsed mid-RUN between clock edges → outputs take reset values immediately. After release, FOLD=1 build gives CLR at T+1, RUN T+2..T+257, and all_done at T+258.

Source files
------------

// File: rtl/in_bsg_ctrl.sv
// Input bitstream generator sequencer for the folded FC layer.
// Latches one activation vector, then runs FOLD clear+stream passes of 2^INWD bits.
module in_bsg_ctrl #(
  parameter int DIM_IN = 16,
  parameter int INWD   = 8,
  parameter int FOLD   = 2,
  parameter int FW     = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM_IN*INWD-1:0] in_data,
  input  logic                   stall,
  input  logic                   abort,
  output logic [DIM_IN*INWD-1:0] bsg_in,
  output logic                   bsg_enable,
  output logic                   rng_clr,
  output logic [FW-1:0]          fold_idx,
  output logic [INWD-1:0]        cyc_cnt,
  output logic                   last_cycle,
  output logic                   pass_done,
  output logic                   all_done
);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  localparam logic [INWD-1:0] CYC_LAST  = '1;
  localparam logic [FW-1:0]   FOLD_LAST = FW'(FOLD - 1);

  state_t state;

  assign in_ready   = (state == IDLE);
  assign rng_clr    = (state == CLR);
  assign bsg_enable = (state == RUN) && !stall;
  assign last_cycle = bsg_enable && (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bsg_in    <= '0;
      cyc_cnt   <= '0;
      fold_idx  <= '0;
      pass_done <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      all_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            bsg_in   <= in_data;
            fold_idx <= '0;
            cyc_cnt  <= '0;
            state    <= CLR;
          end
        end
        CLR: begin
          if (abort) begin
            fold_idx <= '0;
            cyc_cnt  <= '0;
            state    <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // abort wins over both stall and pass completion
          if (abort) begin
            fold_idx <= '0;
            cyc_cnt  <= '0;
            state    <= IDLE;
          end else if (bsg_enable) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (cyc_cnt == CYC_LAST) begin
              pass_done <= 1'b1;
              if (fold_idx == FOLD_LAST) begin
                all_done <= 1'b1;
                state    <= DONE;
              end else begin
                fold_idx <= fold_idx + 1'b1;
                state    <= CLR;
              end
            end
          end
        end
        DONE: begin
          if (abort) begin
            fold_idx <= '0;
            cyc_cnt  <= '0;
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_bsg_ctrl.sv
// Scoreboard bench for in_bsg_ctrl: stimulus queues expected clr/done events,
// a negedge monitor pops and compares them and checks per-cycle invariants.
`timescale 1ns/1ps
module tb_in_bsg_ctrl;

  localparam int DIM_IN = 16;
  localparam int INWD   = 8;
  localparam int FOLD   = 2;
  localparam int FW     = 1;
  localparam int W      = DIM_IN * INWD;
  localparam int BSL    = 256;

  typedef struct packed {
    logic [31:0] cyc;
    logic        clr;
    logic        pd;
    logic        ad;
    logic [FW-1:0] fold;
    logic [15:0] ones;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          stall = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  bsg_in;
  logic          bsg_enable, rng_clr, last_cycle, pass_done, all_done;
  logic [FW-1:0] fold_idx;
  logic [INWD-1:0] cyc_cnt;

  logic          v1 = 1'b0;
  logic          rdy1;
  logic [W-1:0]  d1 = '0;
  logic          stall1 = 1'b0;
  logic          abort1 = 1'b0;
  logic [W-1:0]  bsg_in1;
  logic          en1, clr1, last1, pd1, ad1;
  logic [0:0]    fold1;
  logic [INWD-1:0] cyc1;

  in_bsg_ctrl #(.DIM_IN(DIM_IN), .INWD(INWD), .FOLD(FOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .abort(abort), .bsg_in(bsg_in),
    .bsg_enable(bsg_enable), .rng_clr(rng_clr), .fold_idx(fold_idx),
    .cyc_cnt(cyc_cnt), .last_cycle(last_cycle), .pass_done(pass_done),
    .all_done(all_done)
  );

  in_bsg_ctrl #(.DIM_IN(DIM_IN), .INWD(INWD), .FOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .stall(stall1), .abort(abort1), .bsg_in(bsg_in1),
    .bsg_enable(en1), .rng_clr(clr1), .fold_idx(fold1),
    .cyc_cnt(cyc1), .last_cycle(last1), .pass_done(pd1),
    .all_done(ad1)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int ones = 0;
  logic [W-1:0] cur_vec = '0;
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic clr, input logic pd,
                         input logic ad, input int f, input int o);
    ev_t e;
    e.cyc  = 32'(c);
    e.clr  = clr;
    e.pd   = pd;
    e.ad   = ad;
    e.fold = FW'(f);
    e.ones = 16'(o);
    exp_q.push_back(e);
  endtask

  // s0: stall cycles in pass 0, s1: stall cycles in pass 1
  task automatic send(input logic [W-1:0] v, input int s0, input int s1,
                      output int t);
    int n;
    int x;
    n = 0;
    x = int'(v[7:0]);
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      t = cyc;
      return;
    end
    t = cyc;
    for (int k = 0; k < FOLD; k++)
      push_ev(t + 1 + k * (BSL + 1) + (k > 0 ? s0 : 0), 1'b1, k > 0,
              1'b0, k, k > 0 ? x : 0);
    push_ev(t + 1 + FOLD * (BSL + 1) + s0 + s1, 1'b0, 1'b1, 1'b1,
            FOLD - 1, x);
    @(posedge clk);
    #1;
    cur_vec = v;
  endtask

  always @(negedge clk) begin : mon
    ev_t o;
    ev_t e;
    if (!rst) begin
      chk("en_clr_excl", 64'(bsg_enable & rng_clr), 64'd0);
      chk("last_wo_en", 64'(last_cycle & ~bsg_enable), 64'd0);
      chk("bsg_in_hold", 64'(bsg_in[63:0]), 64'(cur_vec[63:0]));
      if (rng_clr || pass_done || all_done) begin
        o.cyc  = 32'(cyc);
        o.clr  = rng_clr;
        o.pd   = pass_done;
        o.ad   = all_done;
        o.fold = fold_idx;
        o.ones = pass_done ? 16'(ones) : 16'd0;
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_event: got cyc=%0d clr=%b pd=%b ad=%b expected none",
                   cyc, rng_clr, pass_done, all_done);
        end else begin
          e = exp_q.pop_front();
          chk("event", 64'(o), 64'(e));
        end
      end
      if (rng_clr) ones = 0;
      else if (bsg_enable && rev8(cyc_cnt) < bsg_in[7:0]) ones++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  localparam logic [W-1:0] VA = {{15{8'h11}}, 8'h40};
  localparam logic [W-1:0] VB = {{15{8'h5A}}, 8'hA3};
  localparam logic [W-1:0] VC = {{15{8'hC3}}, 8'h07};

  initial begin
    int t, ta, tb2, n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bsg_in", 64'(bsg_in[63:0]), 64'd0);
    chk("rst_cyc_fold", 64'({cyc_cnt, fold_idx}), 64'd0);
    chk("rst_outs", 64'({bsg_enable, rng_clr, last_cycle, pass_done, all_done}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(VA, 0, 0, t);
    in_valid = 1'b0;
    wait_cyc(t + 2);
    chk("nom_en_first", 64'({bsg_enable, cyc_cnt}), 64'({1'b1, 8'd0}));
    wait_cyc(t + 257);
    chk("nom_last0", 64'({last_cycle, cyc_cnt}), 64'({1'b1, 8'd255}));
    wait_cyc(t + 259);
    chk("nom_fold1", 64'(fold_idx), 64'd1);
    wait_cyc(t + 515);
    chk("nom_rdy_done", 64'(in_ready), 64'd0);
    wait_cyc(t + 516);
    chk("nom_rdy_after", 64'(in_ready), 64'd1);

    send(VB, 10, 3, t);
    in_valid = 1'b0;
    wait_cyc(t + 100);
    stall = 1'b1;
    #1;
    chk("stall_freeze_a", 64'({bsg_enable, cyc_cnt}), 64'({1'b0, 8'd98}));
    wait_cyc(t + 109);
    chk("stall_freeze_b", 64'({bsg_enable, cyc_cnt}), 64'({1'b0, 8'd98}));
    wait_cyc(t + 110);
    stall = 1'b0;
    #1;
    chk("stall_resume", 64'({bsg_enable, cyc_cnt}), 64'({1'b1, 8'd98}));
    wait_cyc(t + 111);
    chk("stall_count", 64'(cyc_cnt), 64'd99);
    wait_cyc(t + 524);
    chk("lstall_pos", 64'({fold_idx, cyc_cnt}), 64'({1'b1, 8'd255}));
    stall = 1'b1;
    #1;
    chk("lstall_last_a", 64'(last_cycle), 64'd0);
    wait_cyc(t + 526);
    chk("lstall_last_b", 64'(last_cycle), 64'd0);
    wait_cyc(t + 527);
    stall = 1'b0;
    #1;
    chk("lstall_last_c", 64'(last_cycle), 64'd1);
    wait_cyc(t + 529);
    chk("lstall_rdy", 64'(in_ready), 64'd1);

    send(VA, 0, 0, ta);
    send(VB, 0, 0, tb2);
    in_valid = 1'b0;
    chk("b2b_accept", 64'(tb2 - ta), 64'd516);
    wait_cyc(tb2 + 516);
    chk("b2b_rdy", 64'(in_ready), 64'd1);

    send(VC, 0, 0, t);
    in_valid = 1'b0;
    wait_cyc(t + 409);
    chk("abort_pos", 64'({fold_idx, cyc_cnt}), 64'({1'b1, 8'd150}));
    exp_q.delete();
    abort = 1'b1;
    wait_cyc(t + 410);
    abort = 1'b0;
    chk("abort_idle", 64'({in_ready, fold_idx, cyc_cnt}), 64'({1'b1, 1'b0, 8'd0}));
    wait_cyc(t + 700);
    send(VA, 0, 0, t);
    in_valid = 1'b0;
    wait_cyc(t + 2);
    chk("abort_restart", 64'({bsg_enable, fold_idx, cyc_cnt}), 64'({1'b1, 1'b0, 8'd0}));
    wait_cyc(t + 516);
    chk("abort_rdy", 64'(in_ready), 64'd1);

    send(VB, 0, 0, t);
    in_valid = 1'b0;
    wait_cyc(t + 100);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("arst_bsg_in", 64'(bsg_in[63:0]), 64'd0);
    chk("arst_state", 64'({in_ready, bsg_enable, fold_idx, cyc_cnt}),
        64'({1'b1, 1'b0, 1'b0, 8'd0}));
    cur_vec = '0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    d1 = VC;
    v1 = 1'b1;
    n = 0;
    while (!rdy1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    t = cyc;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    chk("f1_clr", 64'({clr1, en1}), 64'({1'b1, 1'b0}));
    wait_cyc(t + 2);
    chk("f1_en_first", 64'({en1, cyc1}), 64'({1'b1, 8'd0}));
    wait_cyc(t + 257);
    chk("f1_last", 64'({en1, last1, cyc1}), 64'({1'b1, 1'b1, 8'd255}));
    wait_cyc(t + 258);
    chk("f1_done", 64'({en1, pd1, ad1, fold1}), 64'({1'b0, 1'b1, 1'b1, 1'b0}));
    wait_cyc(t + 259);
    chk("f1_rdy", 64'({rdy1, ad1}), 64'({1'b1, 1'b0}));

    wait_cyc(cyc + 5);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
